sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
- Shares one multicycle sqrt unit (start/busy handshake, 10-bit operand, 5-bit result) between N requesters.
- Uses round-robin arbitration.
- Latches the granted operand, sequences the start pulse, and waits for completion.
- Returns the result with a one-hot done pulse.
- A timeout guards against a stuck busy signal.
- Sits between the top-level function controllers and a single shared sqrt instance.

Parameters:
N, 4, number of requesters (2..8)
AW, 10, operand width
YW, 5, result width
TIMEOUT, 64, max cycles in WAIT before abort; 0 disables the timeout

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req_i  in  N  per-requester request level; held until that requester's done_o
a_bi  in  N*AW  operands; requester k at bits [k*AW +: AW]; stable while req high
gnt_o  out  N  one-hot; high from grant edge until the done edge
done_o  out  N  one-hot, one-cycle completion pulse
y_bo  out  YW  result; valid with done_o; held until the next done
err_o  out  1  one-cycle pulse coincident with done_o on timeout
busy_o  out  1  high whenever state != IDLE
sqrt_a_bo  out  AW  operand to the sqrt unit
sqrt_start_o  out  1  one-cycle start pulse to the sqrt unit
sqrt_busy_i  in  1  sqrt busy; rises on the edge that samples start
sqrt_y_bi  in  YW  sqrt result; valid when busy is low

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE, ptr=0, idx=0, tcnt=0.
  - All outputs 0: gnt_o, done_o, y_bo, err_o, sqrt_a_bo, sqrt_start_o.
- States: IDLE, ISSUE, ARM, WAIT. All outputs are registered.
- IDLE:
  - Eligible set = req_i & ~done_o. A requester pulsing done this cycle is masked.
  - Grants only if the eligible set is nonzero and sqrt_busy_i==0.
  - Selection: first eligible index scanning ptr, ptr+1, ..., wrapping mod N.
  - On grant edge: idx<=k, gnt_o<=onehot(k), sqrt_a_bo<=a_bi[k*AW +: AW], ->ISSUE.
  - done_o and err_o are cleared on every edge in which they are not being set.
- ISSUE: sqrt_start_o<=1, ->ARM.
- ARM:
  - sqrt_start_o<=0, tcnt<=0, ->WAIT.
  - sqrt_busy_i is ignored here; the slave's busy is not yet visible.
- WAIT:
  - sqrt_busy_i==0: y_bo<=sqrt_y_bi, done_o<=onehot(idx), gnt_o<=0, ptr<=(idx+1) mod N, ->IDLE.
  - Else, if TIMEOUT!=0 and tcnt==TIMEOUT-1: y_bo<=0, err_o<=1, done_o<=onehot(idx), gnt_o<=0, ptr<=(idx+1) mod N, ->IDLE.
  - Else tcnt<=tcnt+1.
- Latency:
  - Grant edge to start high: 1 cycle. Start is high exactly 1 cycle.
  - Earliest done: 3 edges after grant.
  - Back-to-back: a new grant is possible on the edge after a done.
- Requester drops req mid-operation: the operation still completes; done_o and y_bo are issued normally.
- After a timeout, IDLE holds off granting until sqrt_busy_i falls. No second start is issued into a busy unit.
- Simultaneous requests are resolved purely by ptr. Pointer wrap: idx=N-1 gives ptr=0.
- y_bo changes only on a done edge; it is stable between completions.
- Reset asserted mid-operation aborts immediately:
  - No done_o is issued.
  - The sqrt unit is expected to share the reset.

Test Plan:
- Single request: req_i=0001, a=100 -> gnt_o=0001 next edge; sqrt_start_o one cycle; done_o=0001 with y_bo=10; busy_o low afterwards.
- All four requesting from reset, operands 0,1,1023,255 -> done order 0,1,2,3 with y_bo 0,1,31,15; gnt_o one-hot throughout; no start while sqrt busy.
- Fairness: requester 2 served, then req_i=0101 -> requester 0 served next (ptr=3 wraps to 0), then requester 2. No requester is granted twice while another is eligible.
- Done masking: single requester keeps req_i high one cycle after done_o -> no spurious regrant that cycle; regrant on the following edge if req is still high.
- Timeout, TIMEOUT=8, model holds busy high -> done_o and err_o pulse 8 cycles into WAIT with y_bo=0. A pending request is not granted until busy falls, then proceeds normally.
- Reset low during WAIT -> all outputs 0 immediately (asynchronous), no done_o. After release, ptr=0 and the next request is granted normally.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one multicycle sqrt unit between N requesters.
// It latches the winner's operand, pulses start, waits for completion and returns a one-hot done.
module sqrt_arbiter #(
    parameter int N       = 4,
    parameter int AW      = 10,
    parameter int YW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*AW-1:0] a_bi,
    output logic [N-1:0]    gnt_o,
    output logic [N-1:0]    done_o,
    output logic [YW-1:0]   y_bo,
    output logic            err_o,
    output logic            busy_o,
    output logic [AW-1:0]   sqrt_a_bo,
    output logic            sqrt_start_o,
    input  logic            sqrt_busy_i,
    input  logic [YW-1:0]   sqrt_y_bi,
    output logic [1:0]      dbg_state_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_idx;
    logic [TW-1:0]   r_tcnt;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    r_done;
    logic [YW-1:0]   r_y;
    logic            r_err;
    logic [AW-1:0]   r_a;
    logic            r_start;

    logic [N-1:0]    w_elig;
    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic [CW-1:0]   w_cand;
    logic [PW-1:0]   w_next;

    // Scan from ptr upward with wrap; iterating in reverse lets the nearest candidate win.
    always_comb begin
        w_elig  = req_i & ~r_done;
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = CW'(r_ptr) + CW'(i);
            if (w_cand >= CW'(N)) begin
                w_cand = w_cand - CW'(N);
            end
            if (w_elig[w_cand[PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[PW-1:0];
            end
        end
    end

    assign w_next = (r_idx == PW'(N - 1)) ? '0 : r_idx + PW'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_tcnt  <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_y     <= '0;
            r_err   <= 1'b0;
            r_a     <= '0;
            r_start <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !sqrt_busy_i) begin
                        r_idx   <= w_pick;
                        r_gnt   <= N'(1) << w_pick;
                        r_a     <= a_bi[int'(w_pick)*AW +: AW];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b1;
                    r_state <= S_ARM;
                end
                // The slave's busy only becomes visible after this edge, so it is not sampled here.
                S_ARM: begin
                    r_start <= 1'b0;
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!sqrt_busy_i) begin
                        r_y     <= sqrt_y_bi;
                        r_done  <= N'(1) << r_idx;
                        r_gnt   <= '0;
                        r_ptr   <= w_next;
                        r_state <= S_IDLE;
                    end else if (TO_EN && (r_tcnt == TLAST)) begin
                        r_y     <= '0;
                        r_err   <= 1'b1;
                        r_done  <= N'(1) << r_idx;
                        r_gnt   <= '0;
                        r_ptr   <= w_next;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign done_o       = r_done;
    assign y_bo         = r_y;
    assign err_o        = r_err;
    assign sqrt_a_bo    = r_a;
    assign sqrt_start_o = r_start;
    assign busy_o       = (r_state != S_IDLE);
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural sqrt slave, round-robin reference monitor and scenario tasks.
// Handshake: req_i is held until that requester's done_o; start is sampled by the slave, which raises busy on that edge.
module tb_sqrt_arbiter;
    localparam int N       = 4;
    localparam int AW      = 10;
    localparam int YW      = 5;
    localparam int TIMEOUT = 8;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [N-1:0]    req_i = '0;
    logic [N*AW-1:0] a_bi  = '0;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    done_o;
    logic [YW-1:0]   y_bo;
    logic            err_o;
    logic            busy_o;
    logic [AW-1:0]   sqrt_a_bo;
    logic            sqrt_start_o;
    logic            s_busy;
    logic [YW-1:0]   s_y;
    logic [1:0]      dbg_state;

    int errors = 0;
    int checks = 0;
    logic [N+YW-1:0] exp_q[$];
    bit auto_release = 1'b1;
    int fixed_lat    = 3;

    sqrt_arbiter #(.N(N), .AW(AW), .YW(YW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .a_bi         (a_bi),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .y_bo         (y_bo),
        .err_o        (err_o),
        .busy_o       (busy_o),
        .sqrt_a_bo    (sqrt_a_bo),
        .sqrt_start_o (sqrt_start_o),
        .sqrt_busy_i  (s_busy),
        .sqrt_y_bi    (s_y),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [YW-1:0] isqrt(input logic [AW-1:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return YW'(r);
    endfunction

    // ---------------- sqrt slave model ----------------
    int s_cnt  = 0;
    int op_lat = 0;
    int s_lat;
    logic [YW-1:0] s_res;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s_busy <= 1'b0;
            s_y    <= '0;
            s_res  <= '0;
            s_cnt  <= 0;
            op_lat <= 0;
        end else if (sqrt_start_o) begin
            if (fixed_lat != 0) s_lat = fixed_lat;
            else s_lat = ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(1, 6));
            s_busy <= 1'b1;
            s_cnt  <= s_lat;
            op_lat <= s_lat;
            s_res  <= isqrt(sqrt_a_bo);
            s_y    <= ~isqrt(sqrt_a_bo);
        end else if (s_busy) begin
            if (s_cnt <= 1) begin
                s_busy <= 1'b0;
                s_y    <= s_res;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
    end

    // Requesters drop req on their done pulse unless a test holds it.
    always @(negedge clk_i) begin
        if (auto_release) req_i = req_i & ~done_o;
    end

    // ---------------- reference monitor / scoreboard ----------------
    logic [N-1:0] edge_elig;
    bit           edge_sbusy;
    int           cyc = 0;

    always @(posedge clk_i) begin
        edge_elig  <= req_i & ~done_o;
        edge_sbusy <= s_busy;
        cyc        <= cyc + 1;
    end

    int model_ptr = 0;
    int cur_k     = 0;
    int grant_cyc = 0;
    int n_done    = 0;
    bit in_op     = 1'b0;
    logic [AW-1:0] op_a = '0;
    logic [YW-1:0] last_y = '0;
    bit            mon_found;
    int            mon_k, mon_j, mon_exp_lat;
    bit            mon_exp_err;
    logic [YW-1:0] mon_exp_y;
    logic [N+YW-1:0] mon_item;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            model_ptr = 0;
            in_op     = 1'b0;
            last_y    = '0;
        end else begin
            if (done_o != '0) begin
                n_done++;
                mon_exp_err = (op_lat >= TIMEOUT);
                mon_exp_y   = mon_exp_err ? '0 : isqrt(op_a);
                mon_exp_lat = mon_exp_err ? (2 + TIMEOUT) : (3 + op_lat);
                checks++;
                if (!in_op || done_o !== (N'(1) << cur_k)) begin
                    errors++;
                    $display("FAIL done_id: done_o=%b required=%b (op active=%0d)", done_o, N'(1) << cur_k, in_op);
                end
                checks++;
                if (err_o !== mon_exp_err) begin
                    errors++;
                    $display("FAIL done_err: err_o=%b required=%b", err_o, mon_exp_err);
                end
                checks++;
                if (y_bo !== mon_exp_y) begin
                    errors++;
                    $display("FAIL done_y: y_bo=%0d required=%0d (a=%0d)", y_bo, mon_exp_y, op_a);
                end
                checks++;
                if (cyc - grant_cyc != mon_exp_lat) begin
                    errors++;
                    $display("FAIL done_latency: %0d edges after grant, required %0d", cyc - grant_cyc, mon_exp_lat);
                end
                checks++;
                if (gnt_o !== '0) begin
                    errors++;
                    $display("FAIL gnt_clear: gnt_o=%b required=0 with done", gnt_o);
                end
                if (exp_q.size() > 0) begin
                    mon_item = exp_q.pop_front();
                    checks++;
                    if ({done_o, y_bo} !== mon_item) begin
                        errors++;
                        $display("FAIL order: done_o=%b y_bo=%0d required done_o=%b y_bo=%0d",
                                 done_o, y_bo, mon_item[N+YW-1:YW], mon_item[YW-1:0]);
                    end
                end
                last_y    = mon_exp_y;
                model_ptr = (cur_k + 1) % N;
                in_op     = 1'b0;
            end else begin
                checks++;
                if (y_bo !== last_y || err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL y_hold: y_bo=%0d err_o=%b required y_bo=%0d err_o=0", y_bo, err_o, last_y);
                end
            end

            if (!in_op && gnt_o != '0) begin
                mon_found = 1'b0;
                mon_k     = 0;
                for (int i = N - 1; i >= 0; i--) begin
                    mon_j = (model_ptr + i) % N;
                    if (edge_elig[mon_j]) begin
                        mon_found = 1'b1;
                        mon_k     = mon_j;
                    end
                end
                checks++;
                if (!mon_found || gnt_o !== (N'(1) << mon_k)) begin
                    errors++;
                    $display("FAIL grant_pick: gnt_o=%b required=%b (eligible=%b ptr=%0d)",
                             gnt_o, mon_found ? (N'(1) << mon_k) : N'(0), edge_elig, model_ptr);
                end
                checks++;
                if (edge_sbusy) begin
                    errors++;
                    $display("FAIL grant_busy: granted while sqrt busy=1, required busy=0");
                end
                cur_k = mon_k;
                op_a  = a_bi[mon_k*AW +: AW];
                checks++;
                if (sqrt_a_bo !== op_a) begin
                    errors++;
                    $display("FAIL operand: sqrt_a_bo=%0d required=%0d", sqrt_a_bo, op_a);
                end
                in_op     = 1'b1;
                grant_cyc = cyc;
            end else if (in_op) begin
                checks++;
                if (gnt_o !== (N'(1) << cur_k)) begin
                    errors++;
                    $display("FAIL gnt_hold: gnt_o=%b required=%b", gnt_o, N'(1) << cur_k);
                end
            end

            checks++;
            if (sqrt_start_o !== (in_op && (cyc - grant_cyc == 1))) begin
                errors++;
                $display("FAIL start_timing: start=%b required=%b (%0d edges after grant)",
                         sqrt_start_o, in_op && (cyc - grant_cyc == 1), cyc - grant_cyc);
            end
            if (sqrt_start_o) begin
                checks++;
                if (s_busy) begin
                    errors++;
                    $display("FAIL start_into_busy: start=1 while sqrt busy=1, required busy=0");
                end
            end
            checks++;
            if (busy_o !== in_op) begin
                errors++;
                $display("FAIL busy: busy_o=%b required=%b", busy_o, in_op);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic raise(input int k, input logic [AW-1:0] v);
        a_bi[k*AW +: AW] = v;
        req_i[k] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk_i); #1;
        rst_i = 1'b0;
        req_i = '0;
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    task automatic wait_quiet(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk_i); #1;
            if (req_i == '0 && !busy_o && !s_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (gnt_o !== '0)       begin errors++; $display("FAIL reset_gnt: %b required 0", gnt_o); end
        checks++; if (done_o !== '0)      begin errors++; $display("FAIL reset_done: %b required 0", done_o); end
        checks++; if (y_bo !== '0)        begin errors++; $display("FAIL reset_y: %0d required 0", y_bo); end
        checks++; if (err_o !== 1'b0)     begin errors++; $display("FAIL reset_err: %b required 0", err_o); end
        checks++; if (busy_o !== 1'b0)    begin errors++; $display("FAIL reset_busy: %b required 0", busy_o); end
        checks++; if (sqrt_a_bo !== '0)   begin errors++; $display("FAIL reset_sqrt_a: %0d required 0", sqrt_a_bo); end
        checks++; if (sqrt_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: %b required 0", sqrt_start_o); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: %0d required 0", dbg_state); end
        rst_i = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        @(negedge clk_i); #1;
        fixed_lat = 3;
        raise(0, 10'd100);
        exp_q.push_back({4'b0001, 5'd10});
        @(negedge clk_i); #1;
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL single_gnt: %b required 0001", gnt_o); end
        @(negedge clk_i); #1;
        checks++; if (sqrt_start_o !== 1'b1) begin errors++; $display("FAIL single_start_hi: %b required 1", sqrt_start_o); end
        @(negedge clk_i); #1;
        checks++; if (sqrt_start_o !== 1'b0) begin errors++; $display("FAIL single_start_lo: %b required 0", sqrt_start_o); end
        wait_quiet(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_complete: still busy, required idle"); end
        checks++; if (y_bo !== 5'd10) begin errors++; $display("FAIL single_y: %0d required 10", y_bo); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy: %b required 0", busy_o); end
    endtask

    task automatic test_all_four();
        bit ok;
        do_reset();
        fixed_lat = 4;
        @(negedge clk_i); #1;
        raise(0, 10'd0);
        raise(1, 10'd1);
        raise(2, 10'd1023);
        raise(3, 10'd255);
        exp_q.push_back({4'b0001, 5'd0});
        exp_q.push_back({4'b0010, 5'd1});
        exp_q.push_back({4'b0100, 5'd31});
        exp_q.push_back({4'b1000, 5'd15});
        wait_quiet(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL all4_complete: still busy, required idle"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL all4_count: %0d dones missing, required 0", exp_q.size()); end
        checks++; if (y_bo !== 5'd15) begin errors++; $display("FAIL all4_last_y: %0d required 15", y_bo); end
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        fixed_lat = 2;
        @(negedge clk_i); #1;
        raise(2, 10'd49);
        exp_q.push_back({4'b0100, 5'd7});
        wait_quiet(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fair_first: still busy, required idle"); end
        raise(0, 10'd64);
        raise(2, 10'd81);
        exp_q.push_back({4'b0001, 5'd8});
        exp_q.push_back({4'b0100, 5'd9});
        wait_quiet(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fair_complete: still busy, required idle"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fair_count: %0d dones missing, required 0", exp_q.size()); end
    endtask

    task automatic test_done_mask();
        bit ok;
        bit seen;
        fixed_lat    = 2;
        auto_release = 1'b0;
        @(negedge clk_i); #1;
        raise(1, 10'd144);
        exp_q.push_back({4'b0010, 5'd12});
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i); #1;
            if (done_o[1]) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mask_done: no done for requester 1, required one"); end
        @(negedge clk_i); #1;
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL mask_no_regrant: gnt_o=%b required 0000", gnt_o); end
        @(negedge clk_i); #1;
        checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL mask_regrant: gnt_o=%b required 0010", gnt_o); end
        exp_q.push_back({4'b0010, 5'd12});
        auto_release = 1'b1;
        wait_quiet(40, ok);
        checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL mask_complete: pending=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        fixed_lat = 20;
        @(negedge clk_i); #1;
        raise(3, 10'd400);
        exp_q.push_back({4'b1000, 5'd0});
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i); #1;
            if (gnt_o[3]) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_grant: requester 3 not granted, required grant"); end
        repeat (4) @(negedge clk_i);
        #1;
        fixed_lat = 2;
        raise(0, 10'd9);
        exp_q.push_back({4'b0001, 5'd3});
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i); #1;
            if (done_o[3]) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || err_o !== 1'b1) begin errors++; $display("FAIL to_err: done=%b err_o=%b required done with err=1", seen, err_o); end
        checks++; if (y_bo !== 5'd0) begin errors++; $display("FAIL to_y: %0d required 0", y_bo); end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i); #1;
            if (!s_busy) break;
            checks++;
            if (gnt_o !== '0) begin errors++; $display("FAIL to_holdoff: gnt_o=%b while sqrt busy, required 0", gnt_o); end
        end
        wait_quiet(60, ok);
        checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL to_complete: pending=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        fixed_lat = 6;
        @(negedge clk_i); #1;
        raise(2, 10'd900);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i); #1;
            if (gnt_o[2]) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_grant: requester 2 not granted, required grant"); end
        repeat (4) @(negedge clk_i);
        #3;
        rst_i = 1'b0;
        req_i = '0;
        #1;
        checks++; if (gnt_o !== '0 || done_o !== '0) begin errors++; $display("FAIL rmid_gnt_done: gnt=%b done=%b required 0", gnt_o, done_o); end
        checks++; if (y_bo !== '0 || err_o !== 1'b0) begin errors++; $display("FAIL rmid_y_err: y=%0d err=%b required 0", y_bo, err_o); end
        checks++; if (busy_o !== 1'b0 || sqrt_start_o !== 1'b0 || sqrt_a_bo !== '0) begin
            errors++; $display("FAIL rmid_busy_start: busy=%b start=%b a=%0d required 0", busy_o, sqrt_start_o, sqrt_a_bo);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i); #1;
            checks++;
            if (done_o !== '0) begin errors++; $display("FAIL rmid_no_done: done_o=%b required 0", done_o); end
        end
        rst_i = 1'b1;
        fixed_lat = 3;
        @(negedge clk_i); #1;
        raise(1, 10'd16);
        raise(3, 10'd25);
        exp_q.push_back({4'b0010, 5'd4});
        exp_q.push_back({4'b1000, 5'd5});
        wait_quiet(60, ok);
        checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL rmid_after: pending=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        int start_done;
        fixed_lat  = 0;
        start_done = n_done;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_i); #1;
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] && $urandom_range(0, 3) == 0) raise(k, AW'($urandom_range(0, 1023)));
            end
        end
        wait_quiet(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_drain: still busy, required idle"); end
        checks++; if (n_done - start_done < 20) begin errors++; $display("FAIL rand_throughput: %0d completions, required >= 20", n_done - start_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_done_mask();
        test_timeout();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
